// File: rtl/apb_pkg.sv
// Shared types and constants for the APB wait-state register file.
package apb_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned WCNT_W = 4;

  localparam logic [DATA_W-1:0] ADDR_ID     = 32'h0000_0040;
  localparam logic [DATA_W-1:0] ADDR_WCOUNT = 32'h0000_0041;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/apb_regfile_core.sv
// RW register array plus a wrapping count of committed writes.
module apb_regfile_core
  import apb_pkg::*;
#(
  parameter int unsigned NUM_REGS = 16,
  parameter int unsigned IDX_W    = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we_i,
  input  logic [IDX_W-1:0]  widx_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [IDX_W-1:0]  ridx_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic [DATA_W-1:0] wcount_o
);

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] wcount_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
      wcount_q <= '0;
    end else if (we_i) begin
      regs_q[widx_i] <= wdata_i;
      wcount_q       <= wcount_q + DATA_W'(1);
    end
  end

  assign rdata_o  = regs_q[ridx_i];
  assign wcount_o = wcount_q;

endmodule

// File: rtl/apb_wait_regfile.sv
// APB completer: register bank with programmable wait states and PSLVERR.
module apb_wait_regfile
  import apb_pkg::*;
#(
  parameter int unsigned       NUM_REGS    = 16,
  parameter int unsigned       WAIT_CYCLES = 2,
  parameter logic [DATA_W-1:0] ID_VALUE    = 32'hA5B0_0001
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              PSELx,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [DATA_W-1:0] PADDR,
  input  logic [DATA_W-1:0] PWDATA,
  output logic [DATA_W-1:0] PRDATA,
  output logic              PREADY,
  output logic              PSLVERR
);

  localparam int unsigned IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  state_e            state_q;
  logic [WCNT_W-1:0] wcnt_q;
  logic [IDX_W-1:0]  idx_q;
  logic              write_q;
  logic              err_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic              pready_q;
  logic              pslverr_q;
  logic [DATA_W-1:0] prdata_q;

  logic              in_regs;
  logic              is_id;
  logic              is_wcount;
  logic              err_d;
  logic [DATA_W-1:0] rdata_d;
  logic [DATA_W-1:0] core_rdata;
  logic [DATA_W-1:0] wcount;
  logic              setup;
  logic              commit;

  // Address decode and read mux, sampled only in the setup phase.
  always_comb begin
    in_regs   = (PADDR < DATA_W'(NUM_REGS));
    is_id     = (PADDR == ADDR_ID);
    is_wcount = (PADDR == ADDR_WCOUNT);
    err_d     = !(in_regs || is_id || is_wcount) || (PWRITE && (is_id || is_wcount));
    rdata_d   = '0;
    if (!err_d) begin
      if (in_regs) begin
        rdata_d = core_rdata;
      end else if (is_id) begin
        rdata_d = ID_VALUE;
      end else begin
        rdata_d = wcount;
      end
    end
  end

  assign setup  = PSELx && !PENABLE;
  assign commit = (state_q == RESP) && PSELx && write_q && !err_q;

  // Transfer FSM; response outputs are loaded on the edge entering RESP.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q   <= IDLE;
      wcnt_q    <= '0;
      idx_q     <= '0;
      write_q   <= 1'b0;
      err_q     <= 1'b0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
    end else begin
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
      case (state_q)
        IDLE: begin
          if (setup) begin
            idx_q   <= IDX_W'(PADDR);
            write_q <= PWRITE;
            err_q   <= err_d;
            wdata_q <= PWDATA;
            rdata_q <= rdata_d;
            wcnt_q  <= WCNT_W'(WAIT_CYCLES);
            if (WAIT_CYCLES == 0) begin
              state_q   <= RESP;
              pready_q  <= 1'b1;
              pslverr_q <= err_d;
              prdata_q  <= PWRITE ? '0 : rdata_d;
            end else begin
              state_q <= WAIT;
            end
          end
        end
        WAIT: begin
          if (!PSELx) begin
            state_q <= IDLE;
          end else if (wcnt_q == WCNT_W'(1)) begin
            state_q   <= RESP;
            pready_q  <= 1'b1;
            pslverr_q <= err_q;
            prdata_q  <= write_q ? '0 : rdata_q;
          end else begin
            wcnt_q <= wcnt_q - WCNT_W'(1);
          end
        end
        RESP: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  apb_regfile_core #(
    .NUM_REGS (NUM_REGS),
    .IDX_W    (IDX_W)
  ) u_core (
    .clk      (PCLK),
    .rst_n    (PRESETn),
    .we_i     (commit),
    .widx_i   (idx_q),
    .wdata_i  (wdata_q),
    .ridx_i   (IDX_W'(PADDR)),
    .rdata_o  (core_rdata),
    .wcount_o (wcount)
  );

  assign PREADY  = pready_q;
  assign PSLVERR = pslverr_q;
  assign PRDATA  = prdata_q;

endmodule

// File: tb/tb_apb_wait_regfile.sv
// Directed bench: three completer instances (16 regs/2 waits, 4 regs/2 waits, 4 regs/0 waits).
module tb_apb_wait_regfile;

  logic        PCLK;
  logic        PRESETn;
  logic [2:0]  psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic [2:0]  pready;
  logic [2:0]  pslverr;
  logic [31:0] prdata [3];

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_wc = '0;

  localparam logic [31:0] ID = 32'hA5B0_0001;

  apb_wait_regfile #(.NUM_REGS(16), .WAIT_CYCLES(2), .ID_VALUE(ID)) u_dut0 (
    .PCLK(PCLK), .PRESETn(PRESETn), .PSELx(psel[0]), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PRDATA(prdata[0]), .PREADY(pready[0]), .PSLVERR(pslverr[0]));

  apb_wait_regfile #(.NUM_REGS(4), .WAIT_CYCLES(2), .ID_VALUE(ID)) u_dut1 (
    .PCLK(PCLK), .PRESETn(PRESETn), .PSELx(psel[1]), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PRDATA(prdata[1]), .PREADY(pready[1]), .PSLVERR(pslverr[1]));

  apb_wait_regfile #(.NUM_REGS(4), .WAIT_CYCLES(0), .ID_VALUE(ID)) u_dut2 (
    .PCLK(PCLK), .PRESETn(PRESETn), .PSELx(psel[2]), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PRDATA(prdata[2]), .PREADY(pready[2]), .PSLVERR(pslverr[2]));

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One transfer; returns at the negedge of the completion cycle with the bus still in access.
  task automatic xfer(input int d, input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                      output logic [31:0] rd, output logic err, output int lat);
    @(negedge PCLK);
    psel = '0; psel[d] = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wd;
    @(negedge PCLK);
    penable = 1'b1;
    paddr = ~addr; pwdata = ~wd; pwrite = ~wr;
    lat = 1;
    while (pready[d] !== 1'b1 && lat < 20) begin
      @(negedge PCLK);
      lat++;
    end
    rd = prdata[d];
    err = pslverr[d];
    checks++;
    if (pready[d] !== 1'b1) begin
      errors++;
      $display("FAIL xfer_timeout dut%0d addr=%h: PREADY=%b after %0d cycles, required 1", d, addr, pready[d], lat);
    end
  endtask

  task automatic bus_idle();
    @(negedge PCLK);
    psel = '0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
  endtask

  task automatic test_reset();
    logic [31:0] rd; logic err; int lat;
    psel = '0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
    PRESETn = 1'b0;
    repeat (3) @(negedge PCLK);
    checks++;
    if (pready !== 3'b000) begin errors++; $display("FAIL reset_pready: got %b required 000", pready); end
    checks++;
    if (pslverr !== 3'b000) begin errors++; $display("FAIL reset_pslverr: got %b required 000", pslverr); end
    checks++;
    if (prdata[0] !== 32'h0) begin errors++; $display("FAIL reset_prdata: got %h required 0", prdata[0]); end
    PRESETn = 1'b1;
    exp_wc = '0;
    xfer(0, 1'b0, 32'd0, 32'h0, rd, err, lat);
    bus_idle();
    checks++;
    if (rd !== 32'h0) begin errors++; $display("FAIL reset_read0_data: got %h required 0", rd); end
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL reset_read0_err: got %b required 0", err); end
    checks++;
    if (lat !== 3) begin errors++; $display("FAIL reset_read0_latency: got %0d required 3", lat); end
  endtask

  task automatic test_write_read();
    logic [31:0] rd; logic err; int lat;
    xfer(0, 1'b1, 32'd3, 32'h0000_0002, rd, err, lat);
    bus_idle();
    exp_wc++;
    checks++;
    if (err !== 1'b0 || lat !== 3) begin errors++; $display("FAIL write3_resp: err=%b lat=%0d required err=0 lat=3", err, lat); end
    xfer(0, 1'b0, 32'd3, 32'h0, rd, err, lat);
    bus_idle();
    checks++;
    if (rd !== 32'h0000_0002) begin errors++; $display("FAIL read3_data: got %h required 00000002", rd); end
    xfer(0, 1'b0, 32'h41, 32'h0, rd, err, lat);
    bus_idle();
    checks++;
    if (rd !== 32'd1 || err !== 1'b0) begin errors++; $display("FAIL wcount_after_write: got %h err=%b required 1 err=0", rd, err); end
  endtask

  task automatic test_id();
    logic [31:0] rd; logic err; int lat;
    xfer(0, 1'b0, 32'h40, 32'h0, rd, err, lat);
    bus_idle();
    checks++;
    if (rd !== 32'hA5B0_0001 || err !== 1'b0) begin errors++; $display("FAIL id_read: got %h err=%b required a5b00001 err=0", rd, err); end
    xfer(0, 1'b1, 32'h40, 32'h1234_5678, rd, err, lat);
    bus_idle();
    checks++;
    if (err !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL id_write_err: err=%b data=%h required err=1 data=0", err, rd); end
    xfer(0, 1'b0, 32'h40, 32'h0, rd, err, lat);
    bus_idle();
    checks++;
    if (rd !== 32'hA5B0_0001) begin errors++; $display("FAIL id_unchanged: got %h required a5b00001", rd); end
    xfer(0, 1'b0, 32'h41, 32'h0, rd, err, lat);
    bus_idle();
    checks++;
    if (rd !== exp_wc) begin errors++; $display("FAIL wcount_after_id_write: got %h required %h", rd, exp_wc); end
    xfer(0, 1'b1, 32'h41, 32'h5, rd, err, lat);
    bus_idle();
    checks++;
    if (err !== 1'b1) begin errors++; $display("FAIL wcount_write_err: err=%b required 1", err); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd; logic err; int lat;
    xfer(0, 1'b1, 32'd7, 32'hDEAD_BEEF, rd, err, lat);
    exp_wc++;
    xfer(0, 1'b0, 32'd7, 32'h0, rd, err, lat);
    checks++;
    if (rd !== 32'hDEAD_BEEF || lat !== 3) begin errors++; $display("FAIL b2b_read7: got %h lat=%0d required deadbeef lat=3", rd, lat); end
    xfer(0, 1'b0, 32'h41, 32'h0, rd, err, lat);
    bus_idle();
    checks++;
    if (rd !== exp_wc) begin errors++; $display("FAIL b2b_wcount: got %h required %h", rd, exp_wc); end
  endtask

  task automatic test_unmapped();
    logic [31:0] rd; logic err; int lat;
    xfer(0, 1'b0, 32'h42, 32'h0, rd, err, lat);
    bus_idle();
    checks++;
    if (err !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL unmapped_0x42: err=%b data=%h required err=1 data=0", err, rd); end
    xfer(1, 1'b0, 32'd5, 32'h0, rd, err, lat);
    bus_idle();
    checks++;
    if (err !== 1'b1 || rd !== 32'h0 || lat !== 3) begin errors++; $display("FAIL unmapped_read5_w2: err=%b data=%h lat=%0d required 1/0/3", err, rd, lat); end
    xfer(2, 1'b0, 32'd5, 32'h0, rd, err, lat);
    bus_idle();
    checks++;
    if (err !== 1'b1 || rd !== 32'h0 || lat !== 1) begin errors++; $display("FAIL unmapped_read5_w0: err=%b data=%h lat=%0d required 1/0/1", err, rd, lat); end
    xfer(2, 1'b1, 32'd2, 32'h0000_0077, rd, err, lat);
    checks++;
    if (err !== 1'b0 || lat !== 1) begin errors++; $display("FAIL w0_write2: err=%b lat=%0d required 0/1", err, lat); end
    xfer(2, 1'b0, 32'd2, 32'h0, rd, err, lat);
    bus_idle();
    checks++;
    if (rd !== 32'h0000_0077 || lat !== 1) begin errors++; $display("FAIL w0_read2: got %h lat=%0d required 00000077/1", rd, lat); end
  endtask

  task automatic test_no_setup();
    logic [31:0] rd; logic err; int lat;
    int seen = 0;
    @(negedge PCLK);
    psel = 3'b001; penable = 1'b1; pwrite = 1'b1; paddr = 32'd6; pwdata = 32'hCAFE_0006;
    repeat (4) begin
      @(negedge PCLK);
      if (pready[0] === 1'b1) seen++;
    end
    checks++;
    if (seen !== 0) begin errors++; $display("FAIL no_setup_pready: high in %0d cycles, required 0", seen); end
    bus_idle();
    xfer(0, 1'b0, 32'd6, 32'h0, rd, err, lat);
    bus_idle();
    checks++;
    if (rd !== 32'h0) begin errors++; $display("FAIL no_setup_reg6: got %h required 0", rd); end
  endtask

  task automatic test_abort();
    logic [31:0] rd; logic err; int lat;
    @(negedge PCLK);
    psel = 3'b001; penable = 1'b0; pwrite = 1'b1; paddr = 32'd1; pwdata = 32'h0000_FFFF;
    @(negedge PCLK);
    psel = '0; penable = 1'b0;
    checks++;
    if (pready[0] !== 1'b0) begin errors++; $display("FAIL abort_wait_pready: got %b required 0", pready[0]); end
    repeat (3) @(negedge PCLK);
    checks++;
    if (pready[0] !== 1'b0) begin errors++; $display("FAIL abort_after_pready: got %b required 0", pready[0]); end
    xfer(0, 1'b0, 32'd1, 32'h0, rd, err, lat);
    bus_idle();
    checks++;
    if (rd !== 32'h0 || lat !== 3) begin errors++; $display("FAIL abort_reg1: got %h lat=%0d required 0/3", rd, lat); end
    xfer(0, 1'b0, 32'h41, 32'h0, rd, err, lat);
    bus_idle();
    checks++;
    if (rd !== exp_wc) begin errors++; $display("FAIL abort_wcount: got %h required %h", rd, exp_wc); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; logic err; int lat;
    // reset while a read completes: outputs clear without a clock edge
    xfer(0, 1'b0, 32'd7, 32'h0, rd, err, lat);
    PRESETn = 1'b0;
    #1;
    checks++;
    if (pready[0] !== 1'b0 || prdata[0] !== 32'h0 || pslverr[0] !== 1'b0) begin
      errors++; $display("FAIL reset_async_outputs: pready=%b prdata=%h pslverr=%b required 0/0/0", pready[0], prdata[0], pslverr[0]);
    end
    psel = '0; penable = 1'b0;
    @(negedge PCLK);
    PRESETn = 1'b1;
    exp_wc = '0;
    // reset during WAIT of a write
    @(negedge PCLK);
    psel = 3'b001; penable = 1'b0; pwrite = 1'b1; paddr = 32'd4; pwdata = 32'h0000_0044;
    @(negedge PCLK);
    penable = 1'b1;
    PRESETn = 1'b0;
    #1;
    checks++;
    if (pready[0] !== 1'b0) begin errors++; $display("FAIL reset_wait_pready: got %b required 0", pready[0]); end
    psel = '0; penable = 1'b0;
    @(negedge PCLK);
    PRESETn = 1'b1;
    xfer(0, 1'b0, 32'd4, 32'h0, rd, err, lat);
    bus_idle();
    checks++;
    if (rd !== 32'h0) begin errors++; $display("FAIL reset_wait_reg4: got %h required 0", rd); end
    xfer(0, 1'b0, 32'd3, 32'h0, rd, err, lat);
    bus_idle();
    checks++;
    if (rd !== 32'h0) begin errors++; $display("FAIL reset_clears_reg3: got %h required 0", rd); end
    xfer(0, 1'b0, 32'h41, 32'h0, rd, err, lat);
    bus_idle();
    checks++;
    if (rd !== exp_wc) begin errors++; $display("FAIL reset_clears_wcount: got %h required %h", rd, exp_wc); end
  endtask

  task automatic test_wrap();
    logic [31:0] rd; logic err; int lat;
    @(negedge PCLK);
    force u_dut0.u_core.wcount_q = 32'hFFFF_FFFF;
    @(negedge PCLK);
    release u_dut0.u_core.wcount_q;
    exp_wc = 32'hFFFF_FFFF;
    xfer(0, 1'b0, 32'h41, 32'h0, rd, err, lat);
    bus_idle();
    checks++;
    if (rd !== exp_wc) begin errors++; $display("FAIL wrap_preset: got %h required %h", rd, exp_wc); end
    xfer(0, 1'b1, 32'd0, 32'h1111_1111, rd, err, lat);
    exp_wc++;
    xfer(0, 1'b0, 32'h41, 32'h0, rd, err, lat);
    bus_idle();
    checks++;
    if (rd !== 32'h0 || rd !== exp_wc) begin errors++; $display("FAIL wrap_to_zero: got %h required 00000000", rd); end
    xfer(0, 1'b1, 32'd15, 32'h2222_2222, rd, err, lat);
    exp_wc++;
    xfer(0, 1'b0, 32'h41, 32'h0, rd, err, lat);
    bus_idle();
    checks++;
    if (rd !== 32'h1 || rd !== exp_wc) begin errors++; $display("FAIL wrap_to_one: got %h required 00000001", rd); end
    xfer(0, 1'b0, 32'd15, 32'h0, rd, err, lat);
    bus_idle();
    checks++;
    if (rd !== 32'h2222_2222) begin errors++; $display("FAIL read15: got %h required 22222222", rd); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_id();
    test_back_to_back();
    test_unmapped();
    test_no_setup();
    test_abort();
    test_reset_mid();
    test_wrap();
    repeat (2) @(negedge PCLK);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
